gpio_mul_initiator: RTL

Bus master that drives the gpioemu slave bus (saddress/srd/swr/sdata) from the host side of the same emulated peripheral map. It accepts one multiply command on a valid/ready interface, then issues these bus accesses in order: write A1, write A2, write start, poll status, read W, read L. It returns the product, the popcount and the status flags on a valid/ready response interface. Bench-side and SoC-side logic use it as the single owner of the peripheral's register protocol.

---
 rtl/gpio_mul_initiator.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/gpio_mul_initiator.sv
// gpio_mul_initiator
//   Bus master for the gpioemu slave register map. Accepts one multiply
//   command (cmd_a, cmd_b), then runs the register sequence:
//     write A1, write A2, write start, poll status (with gaps), read W, read L
//   and returns product / ones-count / status flags on a response handshake.
//
//   Every bus access is SETUP (1) + STROBE (STROBE_W) + HOLD (1) cycles.
//   Read data is sampled on the last STROBE cycle.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake, operands cmd_a/cmd_b (24 bit)
//   rsp_valid/rsp_ready  response handshake
//   rsp_product/rsp_ones W and L registers read back
//   rsp_ovf              status bit0 was 0 at completion
//   rsp_timeout          POLL_MAX polls without done
//   rsp_mismatch         self-check failure (0 unless GPIO_MUL_SELF_CHECK_EN)
//   saddress/srd/swr     slave bus address and strobes
//   sdata_out/sdata_in   slave bus write/read data
//
// Build option
//   GPIO_MUL_SELF_CHECK_EN  compare readback against a local a*b and popcount

module gpio_mul_initiator #(
  parameter int unsigned STROBE_W = 2,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned POLL_MAX = 64,
  parameter logic [15:0] ADDR_A1  = 16'h0380,
  parameter logic [15:0] ADDR_A2  = 16'h0388,
  parameter logic [15:0] ADDR_W   = 16'h0390,
  parameter logic [15:0] ADDR_L   = 16'h0398,
  parameter logic [15:0] ADDR_CTL = 16'h03A0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a,
  input  logic [23:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_product,
  output logic [23:0] rsp_ones,
  output logic        rsp_ovf,
  output logic        rsp_timeout,
  output logic        rsp_mismatch,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A1,
    S_WR_A2,
    S_WR_GO,
    S_POLL_GAP,
    S_RD_STAT,
    S_RD_W,
    S_RD_L,
    S_RESP
  } state_t;

  // One counter serves both the access phase and the poll gap.
  localparam int unsigned PH_MAX     = (STROBE_W + 1 > POLL_GAP) ? STROBE_W + 1 : POLL_GAP;
  localparam int unsigned PH_W       = $clog2(PH_MAX + 1);
  localparam int unsigned GAP_LAST_I = (POLL_GAP == 0) ? 0 : POLL_GAP - 1;

  localparam logic [PH_W-1:0] PH_ONE       = PH_W'(1);
  localparam logic [PH_W-1:0] PH_STRB_LAST = PH_W'(STROBE_W);
  localparam logic [PH_W-1:0] PH_HOLD      = PH_W'(STROBE_W + 1);
  localparam logic [PH_W-1:0] PH_GAP_LAST  = PH_W'(GAP_LAST_I);
  localparam logic [15:0]     POLL_LIMIT   = 16'(POLL_MAX);

  state_t          state;
  logic [PH_W-1:0] phase;
  logic [23:0]     op_a;
  logic [23:0]     op_b;
  logic [15:0]     poll_cnt;
  logic [1:0]      stat_q;

  logic        is_write;
  logic        is_read;
  logic        is_access;
  logic        in_strobe;
  logic        acc_last;
  logic        gap_last;
  logic        strb_last;
  logic [15:0] acc_addr;
  logic [31:0] acc_wdata;

  always_comb begin
    is_write  = 1'b0;
    is_read   = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    case (state)
      S_WR_A1:   begin is_write = 1'b1; acc_addr = ADDR_A1;  acc_wdata = {8'h00, op_a}; end
      S_WR_A2:   begin is_write = 1'b1; acc_addr = ADDR_A2;  acc_wdata = {8'h00, op_b}; end
      S_WR_GO:   begin is_write = 1'b1; acc_addr = ADDR_CTL; acc_wdata = 32'h0000_0001; end
      S_RD_STAT: begin is_read  = 1'b1; acc_addr = ADDR_CTL; end
      S_RD_W:    begin is_read  = 1'b1; acc_addr = ADDR_W;   end
      S_RD_L:    begin is_read  = 1'b1; acc_addr = ADDR_L;   end
      default:   ;
    endcase
  end

  assign is_access = is_write | is_read;
  assign in_strobe = (phase != '0) && (phase <= PH_STRB_LAST);
  assign strb_last = (phase == PH_STRB_LAST);
  assign acc_last  = (phase == PH_HOLD);
  assign gap_last  = (phase == PH_GAP_LAST);

  // Bus outputs decode registered state only, so reset clears them next cycle.
  assign saddress  = is_access ? acc_addr : '0;
  assign sdata_out = is_write ? acc_wdata : '0;
  assign srd       = is_read & in_strobe;
  assign swr       = is_write & in_strobe;

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      poll_cnt    <= '0;
      stat_q      <= '0;
      rsp_product <= '0;
      rsp_ones    <= '0;
      rsp_ovf     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (is_access)
        phase <= acc_last ? '0 : phase + PH_ONE;
      else if (state == S_POLL_GAP)
        phase <= gap_last ? '0 : phase + PH_ONE;
      else
        phase <= '0;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_a        <= cmd_a;
            op_b        <= cmd_b;
            poll_cnt    <= '0;
            rsp_product <= '0;
            rsp_ones    <= '0;
            rsp_ovf     <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= S_WR_A1;
          end
        end
        S_WR_A1: if (acc_last) state <= S_WR_A2;
        S_WR_A2: if (acc_last) state <= S_WR_GO;
        S_WR_GO: if (acc_last) state <= (POLL_GAP == 0) ? S_RD_STAT : S_POLL_GAP;
        S_POLL_GAP: if (gap_last) state <= S_RD_STAT;
        S_RD_STAT: begin
          if (strb_last)
            stat_q <= sdata_in[1:0];
          // Decision uses the status captured earlier in this access.
          if (acc_last) begin
            poll_cnt <= poll_cnt + 16'd1;
            if (stat_q[1]) begin
              rsp_ovf <= ~stat_q[0];
              state   <= S_RD_W;
            end else if (poll_cnt + 16'd1 == POLL_LIMIT) begin
              rsp_timeout <= 1'b1;
              rsp_product <= '0;
              rsp_ones    <= '0;
              rsp_ovf     <= 1'b0;
              state       <= S_RESP;
            end else begin
              state <= (POLL_GAP == 0) ? S_RD_STAT : S_POLL_GAP;
            end
          end
        end
        S_RD_W: begin
          if (strb_last) rsp_product <= sdata_in;
          if (acc_last)  state <= S_RD_L;
        end
        S_RD_L: begin
          if (strb_last) rsp_ones <= sdata_in[23:0];
          if (acc_last)  state <= S_RESP;
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GPIO_MUL_SELF_CHECK_EN
  logic [31:0] prod_lo;
  logic [5:0]  prod_ones;
  logic [31:0] exp_prod;
  logic [5:0]  exp_ones;

  always_comb begin
    prod_lo   = 32'(cmd_a) * 32'(cmd_b);
    prod_ones = '0;
    for (int unsigned i = 0; i < 32; i++)
      prod_ones = prod_ones + 6'(prod_lo[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_prod <= '0;
      exp_ones <= '0;
    end else if (state == S_IDLE && cmd_valid) begin
      exp_prod <= prod_lo;
      exp_ones <= prod_ones;
    end
  end

  assign rsp_mismatch = (state == S_RESP) && !rsp_timeout &&
                        ((rsp_product != exp_prod) || (rsp_ones != {18'h0, exp_ones}));
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule
